// File: rtl/ascensor_pkg.sv
// ascensor_pkg: shared state encoding, direction codes and timer sizing for the elevator controller
package ascensor_pkg;

   typedef enum logic [1:0] {REPOSO, SUBIENDO, BAJANDO, PUERTAS} estado_t;

   localparam logic [1:0] DIR_PARADO = 2'b00;
   localparam logic [1:0] DIR_SUBE   = 2'b01;
   localparam logic [1:0] DIR_BAJA   = 2'b10;

   // Width able to hold max(a,b)-1, never narrower than one bit
   function automatic int tmr_w(input int a, input int b);
      int m;
      m = (a > b) ? a : b;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/ascensor_temporizador.sv
// ascensor_temporizador: loadable down-counter shared by travel and door timing
module ascensor_temporizador #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] valor,
   output logic         fin
);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= load ? valor : (cnt != '0) ? cnt - 1'b1 : cnt;

   assign fin = (cnt == '0);

endmodule

// File: rtl/ascensor_ctrl.sv
// ascensor_ctrl: single-car SCAN elevator controller with latched calls and travel/door timers
module ascensor_ctrl
   import ascensor_pkg::*;
#(
   parameter int N_PISOS  = 4,
   parameter int T_VIAJE  = 50_000_000,
   parameter int T_PUERTA = 150_000_000,
   localparam int PISO_W  = $clog2(N_PISOS)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [N_PISOS-1:0] llamada,
   output logic [PISO_W-1:0] piso,
   output logic [1:0]        direccion,
   output logic              puertas_abiertas,
   output logic [N_PISOS-1:0] pendientes
);

   localparam int TW = tmr_w(T_VIAJE, T_PUERTA);
   localparam logic [TW-1:0] V_VIAJE  = TW'(T_VIAJE - 1);
   localparam logic [TW-1:0] V_PUERTA = TW'(T_PUERTA - 1);

   estado_t              estado, estado_sig;
   logic [PISO_W-1:0]    piso_sig;
   logic                 pref_sube, pref_sig;
   logic [N_PISOS-1:0]   clear;
   logic                 load, fin, decidir;
   logic [TW-1:0]        valor;
   logic                 aqui, arriba, abajo, sube, baja;

   function automatic logic hay_arriba(input logic [N_PISOS-1:0] v, input logic [PISO_W-1:0] p);
      hay_arriba = 1'b0;
      for (int i = 0; i < N_PISOS; i++) if (i > int'(p)) hay_arriba = hay_arriba | v[i];
   endfunction

   function automatic logic hay_abajo(input logic [N_PISOS-1:0] v, input logic [PISO_W-1:0] p);
      hay_abajo = 1'b0;
      for (int i = 0; i < N_PISOS; i++) if (i < int'(p)) hay_abajo = hay_abajo | v[i];
   endfunction

   ascensor_temporizador #(.W(TW)) u_tmr (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load),
      .valor (valor),
      .fin   (fin)
   );

   assign aqui   = pendientes[piso];
   assign arriba = hay_arriba(pendientes, piso);
   assign abajo  = hay_abajo(pendientes, piso);
   assign sube   = pref_sube ? arriba : (arriba && !abajo);
   assign baja   = pref_sube ? (abajo && !arriba) : abajo;

   always_comb begin
      estado_sig = estado;
      piso_sig   = piso;
      pref_sig   = pref_sube;
      clear      = '0;
      load       = 1'b0;
      valor      = V_VIAJE;
      decidir    = 1'b0;
      unique case (estado)
         SUBIENDO: if (fin) begin
            piso_sig = piso + 1'b1;
            if (pendientes[piso_sig]) begin
               estado_sig      = PUERTAS;
               clear[piso_sig] = 1'b1;
               load            = 1'b1;
               valor           = V_PUERTA;
            end else if (hay_arriba(pendientes, piso_sig)) load = 1'b1;
            else estado_sig = REPOSO;
         end
         BAJANDO: if (fin) begin
            piso_sig = piso - 1'b1;
            if (pendientes[piso_sig]) begin
               estado_sig      = PUERTAS;
               clear[piso_sig] = 1'b1;
               load            = 1'b1;
               valor           = V_PUERTA;
            end else if (hay_abajo(pendientes, piso_sig)) load = 1'b1;
            else estado_sig = REPOSO;
         end
         PUERTAS: begin
            // A call at the open floor is swallowed and just holds the doors
            clear[piso] = 1'b1;
            if (llamada[piso]) begin
               load  = 1'b1;
               valor = V_PUERTA;
            end else if (fin) decidir = 1'b1;
         end
         default: decidir = 1'b1;
      endcase
      if (decidir) begin
         if (aqui) begin
            estado_sig  = PUERTAS;
            clear[piso] = 1'b1;
            load        = 1'b1;
            valor       = V_PUERTA;
         end else if (sube) begin
            estado_sig = SUBIENDO;
            load       = 1'b1;
            pref_sig   = 1'b1;
         end else if (baja) begin
            estado_sig = BAJANDO;
            load       = 1'b1;
            pref_sig   = 1'b0;
         end else estado_sig = REPOSO;
      end
   end

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         estado           <= REPOSO;
         piso             <= '0;
         pref_sube        <= 1'b1;
         pendientes       <= '0;
         direccion        <= DIR_PARADO;
         puertas_abiertas <= 1'b0;
      end else begin
         estado           <= estado_sig;
         piso             <= piso_sig;
         pref_sube        <= pref_sig;
         pendientes       <= (pendientes | llamada) & ~clear;
         direccion        <= (estado_sig == SUBIENDO) ? DIR_SUBE : (estado_sig == BAJANDO) ? DIR_BAJA : DIR_PARADO;
         puertas_abiertas <= (estado_sig == PUERTAS);
      end

endmodule

// File: tb/tb_ascensor_ctrl.sv
// tb_ascensor_ctrl: directed self-checking bench for ascensor_ctrl with N_PISOS=4, T_VIAJE=4, T_PUERTA=6
module tb_ascensor_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] llamada = '0;
   logic [1:0] piso, direccion;
   logic       puertas_abiertas;
   logic [3:0] pendientes;
   int         total = 0;
   int         bad = 0;

   ascensor_ctrl #(.N_PISOS(4), .T_VIAJE(4), .T_PUERTA(6)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .llamada          (llamada),
      .piso             (piso),
      .direccion        (direccion),
      .puertas_abiertas (puertas_abiertas),
      .pendientes       (pendientes)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic esperar_puertas(input string tag, input logic [1:0] p);
      int n = 0;
      while (puertas_abiertas !== 1'b1 && n < 80) begin
         tick();
         n++;
      end
      chk({tag, " open"}, {31'd0, puertas_abiertas}, 1);
      chk({tag, " floor"}, {30'd0, piso}, {30'd0, p});
   endtask

   task automatic esperar_cierre(input string tag);
      int n = 0;
      while (puertas_abiertas !== 1'b0 && n < 80) begin
         tick();
         n++;
      end
      chk({tag, " closed"}, {31'd0, puertas_abiertas}, 0);
   endtask

   task automatic chk_todo(input string tag, input logic [1:0] p, input logic [1:0] d, input logic po, input logic [3:0] pe);
      chk({tag, " piso"}, {30'd0, piso}, {30'd0, p});
      chk({tag, " dir"}, {30'd0, direccion}, {30'd0, d});
      chk({tag, " puertas"}, {31'd0, puertas_abiertas}, {31'd0, po});
      chk({tag, " pend"}, {28'd0, pendientes}, {28'd0, pe});
   endtask

   initial begin
      // Reset held, then released with no calls
      tick(3);
      chk_todo("rst hold", 2'd0, 2'b00, 1'b0, 4'b0000);
      rst_n = 1'b1;
      tick(3);
      chk_todo("rst idle", 2'd0, 2'b00, 1'b0, 4'b0000);
      // Single call upward to floor 2
      llamada = 4'b0100;
      tick();
      llamada = '0;
      chk_todo("up k+1", 2'd0, 2'b00, 1'b0, 4'b0100);
      tick();
      chk_todo("up k+2", 2'd0, 2'b01, 1'b0, 4'b0100);
      tick(3);
      chk("up k+5 piso", {30'd0, piso}, 0);
      tick();
      chk_todo("up k+6", 2'd1, 2'b01, 1'b0, 4'b0100);
      tick(4);
      chk_todo("up k+10", 2'd2, 2'b00, 1'b1, 4'b0000);
      tick(5);
      chk("up k+15 puertas", {31'd0, puertas_abiertas}, 1);
      tick();
      chk_todo("up k+16", 2'd2, 2'b00, 1'b0, 4'b0000);
      // Door re-open at floor 2
      llamada = 4'b0100;
      tick();
      llamada = '0;
      tick();
      chk_todo("ro open", 2'd2, 2'b00, 1'b1, 4'b0000);
      tick(3);
      llamada = 4'b0100;
      tick();
      llamada = '0;
      chk("ro pend", {28'd0, pendientes}, 0);
      tick(2);
      chk("ro held", {31'd0, puertas_abiertas}, 1);
      tick(3);
      chk("ro last", {31'd0, puertas_abiertas}, 1);
      tick();
      chk_todo("ro close", 2'd2, 2'b00, 1'b0, 4'b0000);
      // Move down to floor 1, then SCAN from there
      llamada = 4'b0010;
      tick();
      llamada = '0;
      tick();
      chk("s4 down dir", {30'd0, direccion}, 2'b10);
      esperar_puertas("s4 f1", 2'd1);
      esperar_cierre("s4 f1");
      llamada = 4'b1000;
      tick();
      llamada = '0;
      tick();
      chk("s4 up dir", {30'd0, direccion}, 2'b01);
      tick();
      llamada = 4'b0101;
      tick();
      llamada = '0;
      chk("s4 pend", {28'd0, pendientes}, 4'b1101);
      esperar_puertas("s4 f2", 2'd2);
      chk("s4 f2 pend", {28'd0, pendientes}, 4'b1001);
      esperar_cierre("s4 f2");
      chk("s4 f2 dir", {30'd0, direccion}, 2'b01);
      esperar_puertas("s4 f3", 2'd3);
      esperar_cierre("s4 f3");
      chk("s4 reverse", {30'd0, direccion}, 2'b10);
      esperar_puertas("s4 f0", 2'd0);
      chk("s4 f0 pend", {28'd0, pendientes}, 4'b0000);
      esperar_cierre("s4 f0");
      // All floors at once from floor 0
      llamada = 4'b1111;
      tick();
      llamada = '0;
      chk("s5 latch", {28'd0, pendientes}, 4'b1111);
      tick();
      chk_todo("s5 f0", 2'd0, 2'b00, 1'b1, 4'b1110);
      esperar_cierre("s5 f0");
      esperar_puertas("s5 f1", 2'd1);
      chk("s5 f1 pend", {28'd0, pendientes}, 4'b1100);
      esperar_cierre("s5 f1");
      esperar_puertas("s5 f2", 2'd2);
      chk("s5 f2 pend", {28'd0, pendientes}, 4'b1000);
      esperar_cierre("s5 f2");
      esperar_puertas("s5 f3", 2'd3);
      chk("s5 f3 pend", {28'd0, pendientes}, 4'b0000);
      esperar_cierre("s5 f3");
      // Reset while travelling up between floors 1 and 2
      llamada = 4'b0010;
      tick();
      llamada = '0;
      esperar_puertas("s6 f1", 2'd1);
      esperar_cierre("s6 f1");
      llamada = 4'b1000;
      tick();
      llamada = 4'b0001;
      tick();
      llamada = '0;
      tick();
      chk_todo("s6 moving", 2'd1, 2'b01, 1'b0, 4'b1001);
      #2 rst_n = 1'b0;
      #1;
      chk_todo("s6 async rst", 2'd0, 2'b00, 1'b0, 4'b0000);
      tick(2);
      rst_n = 1'b1;
      tick(4);
      chk_todo("s6 after rst", 2'd0, 2'b00, 1'b0, 4'b0000);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ascensor_ctrl.md
# ascensor_ctrl

Parametrised single-car elevator controller for N floors. It replaces the fixed-pattern car stimulus with real behaviour: it latches floor calls, runs a SCAN (collective) up/down state machine with per-floor travel and door timers, and drives `piso` / `direccion` / `puertas_abiertas`. These outputs feed the display and LED controllers. The top level instantiates one `ascensor_ctrl` per car.

## Interface
- `N_PISOS`, default 4: number of floors; must be at least 2.
- `T_VIAJE`, default 50_000_000: clock cycles to travel one floor; must be at least 1.
- `T_PUERTA`, default 150_000_000: clock cycles the doors stay open; must be at least 1.
- `PISO_W`: localparam, `$clog2(N_PISOS)`.
- `clk`  in  1: system clock; all state changes on its rising edge.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `llamada`  in  N_PISOS: floor call requests, one bit per floor. A bit may be a pulse or a level and is sampled every cycle.
- `piso`  out  PISO_W: current floor.
- `direccion`  out  2: 00 = stopped, 01 = going up, 10 = going down; 11 is never driven.
- `puertas_abiertas`  out  1: doors open.
- `pendientes`  out  N_PISOS: latched, unserved calls (for LEDs).

## Operation
- **States:** REPOSO, SUBIENDO, BAJANDO, PUERTAS.
- **Internal registers:** shared timer; `pref_sube` (last travel preference).
- **Reset values:**
  - state = REPOSO
  - `piso` = 0
  - `direccion` = 00
  - `puertas_abiertas` = 0
  - `pendientes` = 0
  - timer = 0
  - `pref_sube` = 1
- **Latching:** every cycle, `pendientes <= (pendientes | llamada) & ~clear`.
  - `clear` is the one-hot bit of the floor being served this cycle.
  - `clear` wins over a simultaneous `llamada` on the same bit.
- **Request views:** decisions use the registered `pendientes`.
  - `arriba` = any bit strictly above `piso`.
  - `abajo` = any bit strictly below `piso`.
  - `aqui` = `pendientes[piso]`.
- **Decision function** (used from REPOSO and on door expiry):
  - If `aqui`: go to PUERTAS and clear the bit.
  - Else, if `pref_sube`: `arriba` gives SUBIENDO; otherwise `abajo` gives BAJANDO (set `pref_sube` = 0).
  - Else (`pref_sube` = 0): `abajo` gives BAJANDO; otherwise `arriba` gives SUBIENDO (set `pref_sube` = 1).
  - Else: REPOSO.
- **SUBIENDO / BAJANDO:**
  - The timer loads T_VIAJE-1 on entry and counts down.
  - At 0, `piso` moves by ±1.
  - If the new floor is pending: go to PUERTAS and clear it.
  - Else, if requests remain in the travel direction: reload the timer and continue.
  - Else: go to REPOSO.
  - `piso` never passes 0 or N_PISOS-1.
- **PUERTAS:**
  - The timer loads T_PUERTA-1 on entry.
  - A `llamada` at the current floor while in PUERTAS is not latched. It reloads the timer instead (door re-open).
  - At 0, apply the decision function. Doors close on the same edge.
- **Output decode:**
  - `direccion` = 01 in SUBIENDO, 10 in BAJANDO, 00 otherwise.
  - `puertas_abiertas` = 1 only in PUERTAS.
  - All outputs are registered.
- A `llamada` bit above N_PISOS-1 cannot exist. A call to the current floor while in REPOSO is served as `aqui`.

## Timing
- **Call to latch:** `llamada` asserted in cycle k sets `pendientes` in cycle k+1.
- **Departure / door open from REPOSO:** state and outputs change in cycle k+2.
- **Travel:** `piso` changes exactly T_VIAJE cycles after entering SUBIENDO/BAJANDO.
  - `puertas_abiertas` rises in the same cycle `piso` updates, when that floor is pending.
- **Door open time:** exactly T_PUERTA cycles, measured from entry or from the last reload.
- **Reset:** assertion of `rst_n` forces the reset values immediately, mid-travel or mid-door. Calls in flight are lost.
- **Deassertion:** the first latch occurs on the first rising edge after `rst_n` is high.

## Structure
- **Package `ascensor_pkg`:**
  - state enum (REPOSO, SUBIENDO, BAJANDO, PUERTAS);
  - `direccion` codes DIR_PARADO = 2'b00, DIR_SUBE = 2'b01, DIR_BAJA = 2'b10.
- **Sub-module `ascensor_temporizador`:**
  - loadable down-counter, width `$clog2(max(T_VIAJE, T_PUERTA))`;
  - ports: `load`, `valor`, `fin`;
  - reused for travel and door timing.
- **Top-level integration:** one `ascensor_ctrl` instance per car.

## Test plan
All scenarios use N_PISOS=4, T_VIAJE=4, T_PUERTA=6.
1. **Reset:** hold `rst_n`=0 for 3 cycles -> all outputs 0, `pendientes`=0; release; no calls -> outputs stay 0.
2. **Single call upward:** idle at floor 0, `llamada`=0100 pulse at cycle k -> `direccion`=01 at k+2; `piso`=1 at k+6; `piso`=2 and `puertas_abiertas`=1 at k+10; doors close at k+16 with `direccion`=00 and `pendientes`=0.
3. **Door re-open:** doors open at floor 2; pulse `llamada`[2] 3 cycles after opening -> doors stay open 6 more cycles; `pendientes`[2] stays 0.
4. **SCAN ordering:** car moving up from floor 1 with floor 3 pending; call floors 0 and 2 -> stops at 2, then 3, then reverses (`direccion`=10) and stops at 0.
5. **All floors at once:** idle at 0, `llamada`=1111 -> serves 0, 1, 2, 3 in order; `pendientes` bits clear one by one.
6. **Reset mid-travel:** pull `rst_n` low while in SUBIENDO between floors -> immediately `piso`=0, `direccion`=00, `pendientes`=0.
